// File: rtl/simple_cpu_pkg.sv
// simple_cpu_pkg: opcodes, FSM states and instruction field slicing for simple_cpu_mc
package simple_cpu_pkg;
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_ADDI = 4'h6,
    OP_LD   = 4'h7,
    OP_ST   = 4'h8,
    OP_BEQ  = 4'h9,
    OP_JMP  = 4'hA,
    OP_LI   = 4'hB,
    OP_HALT = 4'hF
  } opcode_e;
  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  function automatic logic [31:0] field(input logic [63:0] w, input int lsb, input int width);
    return 32'((w >> lsb) & ((64'd1 << width) - 64'd1));
  endfunction
  function automatic logic [3:0] f_opcode(input logic [63:0] w, input int rb, input int dw);
    return 4'(field(w, 3 * rb + dw, 4));
  endfunction
  function automatic logic [31:0] f_rd(input logic [63:0] w, input int rb, input int dw);
    return field(w, 2 * rb + dw, rb);
  endfunction
  function automatic logic [31:0] f_rs1(input logic [63:0] w, input int rb, input int dw);
    return field(w, rb + dw, rb);
  endfunction
  function automatic logic [31:0] f_rs2(input logic [63:0] w, input int rb, input int dw);
    return field(w, dw, rb);
  endfunction
  function automatic logic [31:0] f_imm(input logic [63:0] w, input int dw);
    return field(w, 0, dw);
  endfunction
endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile: register file with two combinational read ports and one write port; r0 is always zero
module cpu_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_BITS-1:0]   ra1_i,
  input  logic [REG_BITS-1:0]   ra2_i,
  output logic [DATA_WIDTH-1:0] rd1_o,
  output logic [DATA_WIDTH-1:0] rd2_o,
  input  logic                  we_i,
  input  logic [REG_BITS-1:0]   wa_i,
  input  logic [DATA_WIDTH-1:0] wd_i
);
  logic [DATA_WIDTH-1:0] regs_q [2**REG_BITS];
  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else if (we_i && wa_i != '0) regs_q[wa_i] <= wd_i;
  end
  assign rd1_o = regs_q[ra1_i];
  assign rd2_o = regs_q[ra2_i];
endmodule

// File: rtl/simple_cpu_mc.sv
// simple_cpu_mc: multi-cycle CPU with fetch handshake, FETCH/EXEC/MEM/WB/HALT FSM and inline data memory
module simple_cpu_mc
  import simple_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5,
  parameter int REG_BITS   = 2,
  parameter int PC_BITS    = 8,
  localparam int INSTR_WIDTH = 4 + 3 * REG_BITS + DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_ready,
  output logic [PC_BITS-1:0]     pc,
  output logic                   wb_valid,
  output logic [REG_BITS-1:0]    wb_addr,
  output logic [DATA_WIDTH-1:0]  wb_data,
  output logic                   halted
);
  state_e                 state_q;
  logic [PC_BITS-1:0]     pc_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   wb_valid_q;
  logic [REG_BITS-1:0]    wb_addr_q;
  logic [DATA_WIDTH-1:0]  wb_data_q, st_data_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]  mem_q [2**ADDR_BITS];
  logic [3:0]             op_w;
  logic [REG_BITS-1:0]    rd_w, rs1_w, rs2_w;
  logic [DATA_WIDTH-1:0]  imm_w, a_w, b_w, res_w;
  logic [ADDR_BITS-1:0]   addr_w;
  logic [PC_BITS-1:0]     next_pc_w;
  logic                   wr_w;
  cpu_regfile #(.DATA_WIDTH(DATA_WIDTH), .REG_BITS(REG_BITS)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (rs1_w),
    .ra2_i (rs2_w),
    .rd1_o (a_w),
    .rd2_o (b_w),
    .we_i  (wb_valid_q),
    .wa_i  (wb_addr_q),
    .wd_i  (wb_data_q)
  );
  always_comb begin
    op_w      = f_opcode(64'(instr_q), REG_BITS, DATA_WIDTH);
    rd_w      = REG_BITS'(f_rd(64'(instr_q), REG_BITS, DATA_WIDTH));
    rs1_w     = REG_BITS'(f_rs1(64'(instr_q), REG_BITS, DATA_WIDTH));
    rs2_w     = REG_BITS'(f_rs2(64'(instr_q), REG_BITS, DATA_WIDTH));
    imm_w     = DATA_WIDTH'(f_imm(64'(instr_q), DATA_WIDTH));
    wr_w      = (op_w >= OP_ADD && op_w <= OP_ADDI) || op_w == OP_LI;
    res_w     = op_w == OP_ADD  ? a_w + b_w :
                op_w == OP_SUB  ? a_w - b_w :
                op_w == OP_AND  ? a_w & b_w :
                op_w == OP_OR   ? a_w | b_w :
                op_w == OP_XOR  ? a_w ^ b_w :
                op_w == OP_ADDI ? a_w + imm_w : imm_w;
    addr_w    = ADDR_BITS'(a_w + imm_w);
    next_pc_w = (op_w == OP_BEQ && a_w == b_w) ? pc_q + PC_BITS'($signed(imm_w)) :
                op_w == OP_JMP ? PC_BITS'(imm_w) : pc_q + PC_BITS'(1);
  end
  // wb_valid doubles as the register-file write strobe during WB
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      instr_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      addr_q     <= '0;
      st_data_q  <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        S_FETCH: if (instr_valid) begin
          instr_q <= instr;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          pc_q      <= next_pc_w;
          addr_q    <= addr_w;
          st_data_q <= b_w;
          if (op_w == OP_LD || op_w == OP_ST) state_q <= S_MEM;
          else if (wr_w) begin
            state_q <= S_WB;
            if (rd_w != '0) begin
              wb_valid_q <= 1'b1;
              wb_addr_q  <= rd_w;
              wb_data_q  <= res_w;
            end
          end else state_q <= op_w == OP_HALT ? S_HALT : S_FETCH;
        end
        S_MEM: begin
          state_q <= op_w == OP_LD ? S_WB : S_FETCH;
          if (op_w == OP_LD && rd_w != '0) begin
            wb_valid_q <= 1'b1;
            wb_addr_q  <= rd_w;
            wb_data_q  <= mem_q[addr_q];
          end
        end
        S_WB: state_q <= S_FETCH;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_MEM && op_w == OP_ST) mem_q[addr_q] <= st_data_q;
  end
  assign instr_ready = state_q == S_FETCH;
  assign halted      = state_q == S_HALT;
  assign pc          = pc_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
endmodule

// File: tb/tb_simple_cpu_mc.sv
// tb_simple_cpu_mc: directed scenario tests for simple_cpu_mc with hand-computed expectations
module tb_simple_cpu_mc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [17:0] instr = '0;
  logic        instr_ready;
  logic [7:0]  pc;
  logic        wb_valid;
  logic [1:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        halted;
  int          tests = 0;
  int          fails = 0;
  typedef struct {
    logic [17:0] w;
    int wbn; int wa; int wd; int wcyc; int lat; int pc;
  } row_t;

  simple_cpu_mc dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .pc          (pc),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] enc(input int op, input int rd, input int rs1, input int rs2, input int imm);
    return {4'(op), 2'(rd), 2'(rs1), 2'(rs2), 8'(imm)};
  endfunction

  // Call at a negedge with instr_ready high; returns at the negedge where the core is ready again or halted
  task automatic issue(input logic [17:0] w, output int lat, output int wbn, output logic [1:0] wa,
                       output logic [7:0] wd, output int wcyc);
    wbn = 0; wa = '0; wd = '0; wcyc = 0;
    instr = w;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    lat = 1;
    for (int k = 0; k < 20; k++) begin
      if (wb_valid) begin
        wbn++; wa = wb_addr; wd = wb_data; wcyc = lat;
      end
      if (instr_ready || halted) break;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({instr_ready, halted, wb_valid, wb_addr, wb_data, pc} !== {1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0}) begin
      fails++;
      $display("FAIL reset: got ready=%b halted=%b wbv=%b wba=%0d wbd=%h pc=%h, want 1 0 0 0 00 00",
               instr_ready, halted, wb_valid, wb_addr, wb_data, pc);
    end
  endtask

  task automatic test_alu();
    row_t r[$];
    int lat, wbn, wcyc;
    logic [1:0] wa;
    logic [7:0] wd;
    r.push_back('{enc(11, 1, 0, 0, 8'h05), 1, 1, 8'h05, 2, 3, 1});
    r.push_back('{enc(11, 2, 0, 0, 8'h03), 1, 2, 8'h03, 2, 3, 2});
    r.push_back('{enc(1,  3, 1, 2, 0),     1, 3, 8'h08, 2, 3, 3});
    r.push_back('{enc(11, 1, 0, 0, 8'hF0), 1, 1, 8'hF0, 2, 3, 4});
    r.push_back('{enc(6,  2, 1, 0, 8'h20), 1, 2, 8'h10, 2, 3, 5});
    r.push_back('{enc(2,  3, 0, 1, 0),     1, 3, 8'h10, 2, 3, 6});
    r.push_back('{enc(11, 0, 0, 0, 8'h07), 0, 0, 0,     0, 3, 7});
    r.push_back('{enc(6,  3, 0, 0, 0),     1, 3, 8'h00, 2, 3, 8});
    r.push_back('{enc(5,  1, 1, 2, 0),     1, 1, 8'hE0, 2, 3, 9});
    r.push_back('{enc(4,  3, 1, 2, 0),     1, 3, 8'hF0, 2, 3, 10});
    r.push_back('{enc(3,  2, 1, 3, 0),     1, 2, 8'hE0, 2, 3, 11});
    foreach (r[i]) begin
      issue(r[i].w, lat, wbn, wa, wd, wcyc);
      tests++;
      if (wbn !== r[i].wbn || lat !== r[i].lat || pc !== 8'(r[i].pc) ||
          (r[i].wbn > 0 && (wa !== 2'(r[i].wa) || wd !== 8'(r[i].wd) || wcyc !== r[i].wcyc))) begin
        fails++;
        $display("FAIL alu[%0d]: got wbn=%0d wa=%0d wd=%h wcyc=%0d lat=%0d pc=%h, want wbn=%0d wa=%0d wd=%h wcyc=%0d lat=%0d pc=%h",
                 i, wbn, wa, wd, wcyc, lat, pc, r[i].wbn, r[i].wa, r[i].wd, r[i].wcyc, r[i].lat, r[i].pc);
      end
    end
  endtask

  task automatic test_mem();
    row_t r[$];
    int lat, wbn, wcyc;
    logic [1:0] wa;
    logic [7:0] wd;
    r.push_back('{enc(11, 1, 0, 0, 8'hAA), 1, 1, 8'hAA, 2, 3, 12});
    r.push_back('{enc(11, 2, 0, 0, 8'h04), 1, 2, 8'h04, 2, 3, 13});
    r.push_back('{enc(8,  0, 2, 1, 8'h01), 0, 0, 0,     0, 3, 14});
    r.push_back('{enc(7,  3, 0, 0, 8'h05), 1, 3, 8'hAA, 3, 4, 15});
    r.push_back('{enc(7,  1, 2, 0, 8'h21), 1, 1, 8'hAA, 3, 4, 16});
    r.push_back('{enc(7,  0, 0, 0, 8'h05), 0, 0, 0,     0, 4, 17});
    r.push_back('{enc(8,  0, 0, 2, 8'h1F), 0, 0, 0,     0, 3, 18});
    r.push_back('{enc(7,  3, 2, 0, 8'h1B), 1, 3, 8'h04, 3, 4, 19});
    foreach (r[i]) begin
      issue(r[i].w, lat, wbn, wa, wd, wcyc);
      tests++;
      if (wbn !== r[i].wbn || lat !== r[i].lat || pc !== 8'(r[i].pc) ||
          (r[i].wbn > 0 && (wa !== 2'(r[i].wa) || wd !== 8'(r[i].wd) || wcyc !== r[i].wcyc))) begin
        fails++;
        $display("FAIL mem[%0d]: got wbn=%0d wa=%0d wd=%h wcyc=%0d lat=%0d pc=%h, want wbn=%0d wa=%0d wd=%h wcyc=%0d lat=%0d pc=%h",
                 i, wbn, wa, wd, wcyc, lat, pc, r[i].wbn, r[i].wa, r[i].wd, r[i].wcyc, r[i].lat, r[i].pc);
      end
    end
  endtask

  task automatic test_branch();
    row_t r[$];
    int lat, wbn, wcyc;
    logic [1:0] wa;
    logic [7:0] wd;
    r.push_back('{enc(10, 0, 0, 0, 8'h0A), 0, 0, 0, 0, 2, 8'h0A});
    r.push_back('{enc(9,  0, 0, 0, 8'hFE), 0, 0, 0, 0, 2, 8'h08});
    r.push_back('{enc(0,  0, 0, 0, 0),     0, 0, 0, 0, 2, 8'h09});
    r.push_back('{enc(0,  0, 0, 0, 0),     0, 0, 0, 0, 2, 8'h0A});
    r.push_back('{enc(9,  0, 1, 2, 8'hFE), 0, 0, 0, 0, 2, 8'h0B});
    r.push_back('{enc(9,  0, 2, 3, 8'h03), 0, 0, 0, 0, 2, 8'h0E});
    r.push_back('{enc(10, 0, 0, 0, 8'h40), 0, 0, 0, 0, 2, 8'h40});
    r.push_back('{enc(10, 0, 0, 0, 8'hFF), 0, 0, 0, 0, 2, 8'hFF});
    r.push_back('{enc(0,  0, 0, 0, 0),     0, 0, 0, 0, 2, 8'h00});
    r.push_back('{enc(12, 1, 1, 1, 8'h33), 0, 0, 0, 0, 2, 8'h01});
    r.push_back('{enc(10, 0, 0, 0, 8'h03), 0, 0, 0, 0, 2, 8'h03});
    foreach (r[i]) begin
      issue(r[i].w, lat, wbn, wa, wd, wcyc);
      tests++;
      if (wbn !== r[i].wbn || lat !== r[i].lat || pc !== 8'(r[i].pc)) begin
        fails++;
        $display("FAIL branch[%0d]: got wbn=%0d lat=%0d pc=%h, want wbn=%0d lat=%0d pc=%h",
                 i, wbn, lat, pc, r[i].wbn, r[i].lat, r[i].pc);
      end
    end
  endtask

  task automatic test_halt();
    int lat, wbn, wcyc, bad;
    logic [1:0] wa;
    logic [7:0] wd;
    issue(enc(15, 0, 0, 0, 0), lat, wbn, wa, wd, wcyc);
    tests++;
    if (lat !== 2 || halted !== 1'b1 || instr_ready !== 1'b0 || pc !== 8'h04) begin
      fails++;
      $display("FAIL halt_enter: got lat=%0d halted=%b ready=%b pc=%h, want 2 1 0 04", lat, halted, instr_ready, pc);
    end
    bad = 0;
    instr = enc(11, 1, 0, 0, 8'h77);
    instr_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (halted !== 1'b1 || instr_ready !== 1'b0 || pc !== 8'h04 || wb_valid !== 1'b0) bad++;
    end
    instr_valid = 1'b0;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL halt_hold: got %0d bad cycles, want 0", bad);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (pc !== 8'h00 || halted !== 1'b0 || instr_ready !== 1'b1) begin
      fails++;
      $display("FAIL halt_reset: got pc=%h halted=%b ready=%b, want 00 0 1", pc, halted, instr_ready);
    end
  endtask

  task automatic test_idle();
    int lat, wbn, wcyc, bad;
    logic [1:0] wa;
    logic [7:0] wd;
    bad = 0;
    instr = enc(11, 1, 0, 0, 8'h99);
    repeat (5) begin
      @(negedge clk);
      if (instr_ready !== 1'b1 || pc !== 8'h00 || wb_valid !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL idle: got %0d bad cycles, want 0", bad);
    end
    issue(enc(1, 3, 1, 2, 0), lat, wbn, wa, wd, wcyc);
    tests++;
    if (wbn !== 1 || wa !== 2'd3 || wd !== 8'h00 || lat !== 3 || pc !== 8'h01) begin
      fails++;
      $display("FAIL idle_add: got wbn=%0d wa=%0d wd=%h lat=%0d pc=%h, want 1 3 00 3 01", wbn, wa, wd, lat, pc);
    end
  endtask

  task automatic test_rst_mid_store();
    int lat, wbn, wcyc;
    logic [1:0] wa;
    logic [7:0] wd;
    issue(enc(11, 1, 0, 0, 8'h11), lat, wbn, wa, wd, wcyc);
    issue(enc(8, 0, 0, 1, 0), lat, wbn, wa, wd, wcyc);
    issue(enc(11, 1, 0, 0, 8'h55), lat, wbn, wa, wd, wcyc);
    tests++;
    if (pc !== 8'h04 || wd !== 8'h55) begin
      fails++;
      $display("FAIL pre_store: got pc=%h wd=%h, want 04 55", pc, wd);
    end
    instr = enc(8, 0, 0, 1, 0);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({instr_ready, halted, wb_valid, wb_addr, wb_data, pc} !== {1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0}) begin
      fails++;
      $display("FAIL mid_store_reset: got ready=%b halted=%b wbv=%b wba=%0d wbd=%h pc=%h, want 1 0 0 0 00 00",
               instr_ready, halted, wb_valid, wb_addr, wb_data, pc);
    end
    issue(enc(7, 2, 0, 0, 0), lat, wbn, wa, wd, wcyc);
    tests++;
    if (wbn !== 1 || wa !== 2'd2 || wd !== 8'h11 || lat !== 4 || pc !== 8'h01) begin
      fails++;
      $display("FAIL store_suppressed: got wbn=%0d wa=%0d wd=%h lat=%0d pc=%h, want 1 2 11 4 01", wbn, wa, wd, lat, pc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_halt();
    test_idle();
    test_rst_mid_store();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
